// File: rtl/wiv_pmp_unit.sv
`default_nettype none
// ============================================================================
//  Module   : wiv_pmp_unit
//  Purpose  : Physical memory protection unit. Holds NUM_ENTRIES
//             pmpcfg/pmpaddr CSR pairs with WARL and lock behaviour and
//             checks fetch/load/store accesses through a registered
//             valid/ready request/response port.
//  Revision : 1.0 - initial release
// ============================================================================
module wiv_pmp_unit #(
    parameter int NUM_ENTRIES = 8,
    parameter int PADDR_W     = 56
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [63:0] csr_wdata,
    output logic [63:0] csr_rdata,
    output logic        csr_hit,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_type,
    input  logic        req_priv_m,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_fault
);

    // pmpaddr holds physical address bits [PADDR_W-1:2]
    localparam int c_AW = PADDR_W - 2;
    localparam logic [c_AW-1:0] c_AW_ONE = {{(c_AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        PMP_OFF   = 2'd0,
        PMP_TOR   = 2'd1,
        PMP_NA4   = 2'd2,
        PMP_NAPOT = 2'd3
    } pmp_cfg_mode_t;

    typedef enum logic [1:0] {
        PMP_REQ_EXEC  = 2'd0,
        PMP_REQ_READ  = 2'd1,
        PMP_REQ_WRITE = 2'd2
    } pmp_req_type_t;

    typedef struct packed {
        logic          l;
        logic [1:0]    rsv;
        pmp_cfg_mode_t a;
        logic          x;
        logic          w;
        logic          r;
    } pmp_cfg_t;

    pmp_cfg_t          r_cfg  [NUM_ENTRIES];
    logic [c_AW-1:0]   r_addr [NUM_ENTRIES];
    logic              r_rsp_valid;
    logic              r_rsp_fault;

    pmp_cfg_t               w_cfg_new [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] w_cfg_we;
    logic [NUM_ENTRIES-1:0] w_addr_we;
    logic [NUM_ENTRIES-1:0] w_tor_lock;
    logic [NUM_ENTRIES-1:0] w_tor_lock_above;
    logic [NUM_ENTRIES-1:0] w_match_first;
    logic [NUM_ENTRIES-1:0] w_match_last;
    logic                   w_sel_cfg0;
    logic                   w_sel_cfg2;
    logic                   w_sel_addr;
    logic [PADDR_W-1:0]     w_first;
    logic [PADDR_W-1:0]     w_last;
    logic [2:0]             w_len_m1;
    logic                   w_wrap;
    logic                   w_hit;
    logic                   w_both;
    logic                   w_perm;
    logic                   w_fault;
    pmp_cfg_t               w_sel;
    logic                   w_accept;
    logic                   w_unused;

    // ------------------------------------------------------------------
    // CSR address decode
    // ------------------------------------------------------------------
    assign w_sel_cfg0 = (csr_addr == 12'h3A0);
    assign w_sel_cfg2 = (csr_addr == 12'h3A2) && (NUM_ENTRIES > 8);
    assign w_sel_addr = (csr_addr[11:4] == 8'h3B) && (int'(csr_addr[3:0]) < NUM_ENTRIES);
    assign csr_hit    = w_sel_cfg0 | w_sel_cfg2 | w_sel_addr;

    // Entry i+1 locked as TOR also freezes pmpaddr i (its lower bound)
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_tor_lock[i] = r_cfg[i].l && (r_cfg[i].a == PMP_TOR);
        end
    end
    assign w_tor_lock_above = w_tor_lock >> 1;

    // WARL-legalised cfg bytes and per-entry write enables honouring locks
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_cfg_new[i]     = pmp_cfg_t'(csr_wdata[8*(i%8) +: 8]);
            w_cfg_new[i].rsv = 2'b00;
            if (!w_cfg_new[i].r) begin
                w_cfg_new[i].w = 1'b0;
            end
            w_cfg_we[i]  = csr_we && !r_cfg[i].l && ((i < 8) ? w_sel_cfg0 : w_sel_cfg2);
            w_addr_we[i] = csr_we && w_sel_addr && (csr_addr[3:0] == 4'(i))
                           && !r_cfg[i].l && !w_tor_lock_above[i];
        end
    end

    // CSR storage; reset clears every entry including locked ones
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_cfg[i]  <= '0;
                r_addr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (w_cfg_we[i]) begin
                    r_cfg[i] <= w_cfg_new[i];
                end
                if (w_addr_we[i]) begin
                    r_addr[i] <= csr_wdata[c_AW-1:0];
                end
            end
        end
    end

    // Combinational CSR read; unimplemented bytes and slots read zero
    always_comb begin
        csr_rdata = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if ((i < 8 && w_sel_cfg0) || (i >= 8 && w_sel_cfg2)) begin
                csr_rdata[8*(i%8) +: 8] = r_cfg[i];
            end
            if (w_sel_addr && (csr_addr[3:0] == 4'(i))) begin
                csr_rdata[c_AW-1:0] = r_addr[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Access span: first and last byte, wrapping modulo 2^PADDR_W
    // ------------------------------------------------------------------
    assign w_len_m1 = {req_size == 2'd3, req_size[1], req_size != 2'd0};
    assign w_first  = req_addr[PADDR_W-1:0];
    assign w_last   = w_first + {{(PADDR_W-3){1'b0}}, w_len_m1};
    assign w_wrap   = (w_last < w_first);

    // Per-entry address match of both ends of the access
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_match
        logic [PADDR_W-1:0] w_lo;
        logic [PADDR_W-1:0] w_top;
        logic [c_AW-1:0]    w_mask;
        logic               w_tor_f;
        logic               w_tor_l;

        if (gi == 0) begin : g_lo_zero
            assign w_lo = '0;
        end else begin : g_lo_prev
            assign w_lo = {r_addr[gi-1], 2'b00};
        end

        assign w_top  = {r_addr[gi], 2'b00};
        // Ones above the trailing-ones run of pmpaddr: the NAPOT compare mask
        assign w_mask = ~(r_addr[gi] ^ (r_addr[gi] + c_AW_ONE));

        assign w_tor_f = (w_lo < w_top) && (w_first >= w_lo) && (w_first < w_top);
        assign w_tor_l = (w_lo < w_top) && (w_last  >= w_lo) && (w_last  < w_top);

        assign w_match_first[gi] =
            (r_cfg[gi].a == PMP_TOR)   ? w_tor_f :
            (r_cfg[gi].a == PMP_NA4)   ? (w_first[PADDR_W-1:2] == r_addr[gi]) :
            (r_cfg[gi].a == PMP_NAPOT) ? (((w_first[PADDR_W-1:2] ^ r_addr[gi]) & w_mask) == '0) :
                                         1'b0;
        assign w_match_last[gi] =
            (r_cfg[gi].a == PMP_TOR)   ? w_tor_l :
            (r_cfg[gi].a == PMP_NA4)   ? (w_last[PADDR_W-1:2] == r_addr[gi]) :
            (r_cfg[gi].a == PMP_NAPOT) ? (((w_last[PADDR_W-1:2] ^ r_addr[gi]) & w_mask) == '0) :
                                         1'b0;
    end

    // Lowest-index matching entry decides; partial or wrapped match faults
    always_comb begin
        w_hit  = 1'b0;
        w_both = 1'b0;
        w_sel  = '0;
        w_perm = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (w_match_first[i] || w_match_last[i]) begin
                w_hit  = 1'b1;
                w_both = w_match_first[i] && w_match_last[i];
                w_sel  = r_cfg[i];
            end
        end
        case (pmp_req_type_t'(req_type))
            PMP_REQ_EXEC:  w_perm = w_sel.x;
            PMP_REQ_READ:  w_perm = w_sel.r;
            PMP_REQ_WRITE: w_perm = w_sel.w;
            default:       w_perm = 1'b0;
        endcase
        if (!w_hit) begin
            w_fault = !req_priv_m;
        end else if (w_wrap || !w_both) begin
            w_fault = 1'b1;
        end else if (!w_sel.l && req_priv_m) begin
            w_fault = 1'b0;
        end else begin
            w_fault = !w_perm;
        end
    end

    // ------------------------------------------------------------------
    // Response register with valid/ready handshake
    // ------------------------------------------------------------------
    assign req_ready = !r_rsp_valid || rsp_ready;
    assign w_accept  = req_valid && req_ready;

    // Load on accept, drop when consumed, hold under back-pressure
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_fault <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_fault <= w_fault;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_fault = r_rsp_fault;

    // Address bits above the physical width take no part in checking
    assign w_unused = ^req_addr[63:PADDR_W];

endmodule
`default_nettype wire

// File: tb/tb_wiv_pmp_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wiv_pmp_unit
//  Purpose  : Self-checking bench for wiv_pmp_unit against a behavioural
//             model of the PMP CSRs and access-check rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wiv_pmp_unit;

    localparam int N  = 8;
    localparam int PW = 56;
    localparam longint unsigned c_AMASK = (64'd1 << (PW - 2)) - 64'd1;
    localparam longint unsigned c_PMASK = (64'd1 << PW) - 64'd1;
    localparam logic [1:0] T_EXEC = 2'd0, T_READ = 2'd1, T_WRITE = 2'd2;

    logic        clk;
    logic        rst;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata;
    logic [63:0] csr_rdata;
    logic        csr_hit;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic [1:0]  req_type;
    logic        req_priv_m;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_fault;

    int n_cmp;
    int n_fail;

    logic [7:0]      m_cfg  [16];
    longint unsigned m_addr [16];

    wiv_pmp_unit #(.NUM_ENTRIES(N), .PADDR_W(PW)) dut (
        .clk(clk), .rst(rst),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_hit(csr_hit),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_type(req_type), .req_priv_m(req_priv_m),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_fault(rsp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    function automatic void m_clear();
        for (int e = 0; e < 16; e++) begin
            m_cfg[e]  = 8'h00;
            m_addr[e] = 64'd0;
        end
    endfunction

    function automatic bit m_hit(input logic [11:0] a);
        return (a == 12'h3A0) || (a == 12'h3A2 && N > 8) ||
               (a[11:4] == 8'h3B && int'(a[3:0]) < N);
    endfunction

    function automatic logic [63:0] m_read(input logic [11:0] a);
        logic [63:0] r;
        r = 64'd0;
        for (int j = 0; j < 8; j++) begin
            if (a == 12'h3A0 && j < N) r[8*j +: 8] = m_cfg[j];
            if (a == 12'h3A2 && j + 8 < N) r[8*j +: 8] = m_cfg[j+8];
        end
        if (a[11:4] == 8'h3B && int'(a[3:0]) < N) r = m_addr[int'(a[3:0])];
        return r;
    endfunction

    function automatic void m_write(input logic [11:0] a, input logic [63:0] d);
        logic [7:0] b;
        bit         lk;
        int         e;
        if (a == 12'h3A0 || (a == 12'h3A2 && N > 8)) begin
            for (int j = 0; j < 8; j++) begin
                e = (a == 12'h3A2) ? j + 8 : j;
                if (e < N && !m_cfg[e][7]) begin
                    b = d[8*j +: 8];
                    b[6:5] = 2'b00;
                    if (b[1:0] == 2'b10) b[1] = 1'b0;
                    m_cfg[e] = b;
                end
            end
        end
        if (a[11:4] == 8'h3B && int'(a[3:0]) < N) begin
            e  = int'(a[3:0]);
            lk = m_cfg[e][7];
            if (e + 1 < N) begin
                if (m_cfg[e+1][7] && m_cfg[e+1][4:3] == 2'b01) lk = 1'b1;
            end
            if (!lk) m_addr[e] = d & c_AMASK;
        end
    endfunction

    function automatic bit m_match(input int e, input longint unsigned x);
        longint unsigned lo, top, sz, base;
        int k;
        top = m_addr[e] << 2;
        case (m_cfg[e][4:3])
            2'b01: begin
                lo = 64'd0;
                if (e > 0) lo = m_addr[e-1] << 2;
                return (lo < top) && (x >= lo) && (x < top);
            end
            2'b10: return (x >> 2) == m_addr[e];
            2'b11: begin
                k = 0;
                while (k < PW - 2 && m_addr[e][k]) k++;
                sz   = 64'd1 << (k + 3);
                base = top & ~(sz - 64'd1);
                return (x >= base) && (x < base + sz);
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_fault(input logic [63:0] a, input logic [1:0] sz,
                                   input logic [1:0] ty, input bit pm);
        longint unsigned x0, x1;
        bit m0, m1, perm;
        x0 = a & c_PMASK;
        x1 = (x0 + (64'd1 << sz) - 64'd1) & c_PMASK;
        for (int e = 0; e < N; e++) begin
            m0 = m_match(e, x0);
            m1 = m_match(e, x1);
            if (m0 || m1) begin
                if (x1 < x0 || !(m0 && m1)) return 1'b1;
                if (!m_cfg[e][7] && pm) return 1'b0;
                perm = (ty == T_EXEC) ? m_cfg[e][2] :
                       (ty == T_READ) ? m_cfg[e][0] :
                       (ty == T_WRITE) ? m_cfg[e][1] : 1'b0;
                return !perm;
            end
        end
        return !pm;
    endfunction

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0; csr_we = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_clear();
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [63:0] d);
        @(negedge clk);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        m_write(a, d);
        @(posedge clk);
        #1;
        csr_we = 1'b0;
    endtask

    task automatic csr_rd(input logic [11:0] a, output logic [63:0] d, output logic h);
        @(negedge clk);
        csr_addr = a;
        #1;
        d = csr_rdata;
        h = csr_hit;
    endtask

    task automatic issue(input logic [63:0] a, input logic [1:0] sz, input logic [1:0] ty,
                         input bit pm, output logic f, output logic v);
        @(negedge clk);
        req_addr = a; req_size = sz; req_type = ty; req_priv_m = pm;
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        f = rsp_fault;
        v = rsp_valid;
        req_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [63:0] d; logic h, f, v;
        do_reset();
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_fault !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_fault: got %b want 0", rsp_fault); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        csr_rd(12'h3A0, d, h);
        n_cmp++; if (d !== 64'd0 || h !== 1'b1) begin n_fail++; $display("FAIL reset_cfg0: got %h/%b want 0/1", d, h); end
        issue(64'h1000, 2'd2, T_READ, 1'b0, f, v);
        n_cmp++; if (f !== 1'b1 || v !== 1'b1) begin n_fail++; $display("FAIL reset_s_read: got f=%b v=%b want f=1 v=1", f, v); end
        issue(64'h1000, 2'd2, T_READ, 1'b1, f, v);
        n_cmp++; if (f !== 1'b0 || v !== 1'b1) begin n_fail++; $display("FAIL reset_m_read: got f=%b v=%b want f=0 v=1", f, v); end
    endtask

    task automatic test_tor();
        logic f, v;
        do_reset();
        csr_wr(12'h3B0, 64'h400);
        csr_wr(12'h3B1, 64'h800);
        csr_wr(12'h3A0, 64'h0B00);
        issue(64'h1000, 2'd2, T_WRITE, 1'b0, f, v);
        n_cmp++; if (f !== 1'b0) begin n_fail++; $display("FAIL tor_write_in: got %b want 0", f); end
        issue(64'h2000, 2'd2, T_WRITE, 1'b0, f, v);
        n_cmp++; if (f !== 1'b1) begin n_fail++; $display("FAIL tor_write_out: got %b want 1", f); end
        issue(64'h1800, 2'd2, T_EXEC, 1'b0, f, v);
        n_cmp++; if (f !== 1'b1) begin n_fail++; $display("FAIL tor_exec: got %b want 1", f); end
    endtask

    task automatic test_napot();
        logic f, v;
        do_reset();
        csr_wr(12'h3B0, 64'h1FF);
        csr_wr(12'h3A0, 64'h1F);
        issue(64'hFF8, 2'd3, T_READ, 1'b0, f, v);
        n_cmp++; if (f !== 1'b0) begin n_fail++; $display("FAIL napot_inside: got %b want 0", f); end
        issue(64'hFFC, 2'd3, T_READ, 1'b0, f, v);
        n_cmp++; if (f !== 1'b1) begin n_fail++; $display("FAIL napot_straddle: got %b want 1", f); end
        issue(64'h00FF_FFFF_FFFF_FFFC, 2'd3, T_READ, 1'b1, f, v);
        n_cmp++; if (f !== 1'b1) begin n_fail++; $display("FAIL napot_wrap: got %b want 1", f); end
        issue(64'h2000, 2'd3, T_READ, 1'b1, f, v);
        n_cmp++; if (f !== 1'b0) begin n_fail++; $display("FAIL napot_m_nomatch: got %b want 0", f); end
    endtask

    task automatic test_lock();
        logic [63:0] d; logic h, f, v;
        do_reset();
        csr_wr(12'h3B0, 64'h100);
        csr_wr(12'h3A0, 64'h8C);
        csr_wr(12'h3B0, 64'h200);
        csr_rd(12'h3B0, d, h);
        n_cmp++; if (d !== 64'h100) begin n_fail++; $display("FAIL lock_addr: got %h want 100", d); end
        csr_wr(12'h3A0, 64'h0);
        csr_rd(12'h3A0, d, h);
        n_cmp++; if (d !== 64'h8C) begin n_fail++; $display("FAIL lock_cfg: got %h want 8c", d); end
        issue(64'h10, 2'd2, T_READ, 1'b1, f, v);
        n_cmp++; if (f !== 1'b1) begin n_fail++; $display("FAIL lock_m_read: got %b want 1", f); end
        csr_wr(12'h3B2, 64'h500);
        csr_wr(12'h3A0, 64'h8800_0000);
        csr_rd(12'h3A0, d, h);
        n_cmp++; if (d !== 64'h8800_008C) begin n_fail++; $display("FAIL lock_other_bytes: got %h want 8800008c", d); end
        csr_wr(12'h3B2, 64'h600);
        csr_rd(12'h3B2, d, h);
        n_cmp++; if (d !== 64'h500) begin n_fail++; $display("FAIL lock_tor_below: got %h want 500", d); end
        csr_wr(12'h3B3, 64'h700);
        csr_rd(12'h3B3, d, h);
        n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL lock_self_addr: got %h want 0", d); end
        do_reset();
        csr_rd(12'h3A0, d, h);
        n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL lock_reset_clear: got %h want 0", d); end
    endtask

    task automatic test_warl();
        logic [63:0] d; logic h;
        do_reset();
        csr_wr(12'h3A0, 64'h02);
        csr_rd(12'h3A0, d, h);
        n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL warl_w_only: got %h want 0", d); end
        csr_wr(12'h3A0, 64'h067F);
        csr_rd(12'h3A0, d, h);
        n_cmp++; if (d !== 64'h041F) begin n_fail++; $display("FAIL warl_rsv_bits: got %h want 41f", d); end
        csr_wr(12'h3B1, 64'hFFFF_FFFF_FFFF_FFFF);
        csr_rd(12'h3B1, d, h);
        n_cmp++; if (d !== 64'h003F_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL warl_addr_width: got %h want 3fffffffffffff", d); end
        csr_rd(12'h3A1, d, h);
        n_cmp++; if (d !== 64'h0 || h !== 1'b0) begin n_fail++; $display("FAIL hit_cfg1: got %h/%b want 0/0", d, h); end
        csr_rd(12'h3B8, d, h);
        n_cmp++; if (d !== 64'h0 || h !== 1'b0) begin n_fail++; $display("FAIL hit_addr8: got %h/%b want 0/0", d, h); end
        csr_rd(12'h3B7, d, h);
        n_cmp++; if (h !== 1'b1) begin n_fail++; $display("FAIL hit_addr7: got %b want 1", h); end
    endtask

    task automatic test_csr_same_cycle();
        logic f, v;
        do_reset();
        csr_wr(12'h3B0, 64'h400);
        csr_wr(12'h3A0, 64'h09);
        @(negedge clk);
        req_addr = 64'h10; req_size = 2'd2; req_type = T_READ; req_priv_m = 1'b0;
        req_valid = 1'b1; rsp_ready = 1'b1;
        csr_we = 1'b1; csr_addr = 12'h3A0; csr_wdata = 64'h0;
        @(posedge clk);
        #1;
        m_write(12'h3A0, 64'h0);
        csr_we = 1'b0; req_valid = 1'b0;
        n_cmp++; if (rsp_fault !== 1'b0 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL same_cycle_prewrite: got f=%b v=%b want 0/1", rsp_fault, rsp_valid); end
        issue(64'h10, 2'd2, T_READ, 1'b0, f, v);
        n_cmp++; if (f !== 1'b1) begin n_fail++; $display("FAIL same_cycle_after: got %b want 1", f); end
    endtask

    task automatic test_back_to_back();
        logic exp;
        do_reset();
        csr_wr(12'h3B0, 64'h100);
        csr_wr(12'h3B1, 64'h5FF);
        csr_wr(12'h3A0, 64'h1B0D);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            req_addr = 64'($urandom_range(0, 32'h2800));
            req_size = 2'($urandom_range(0, 3));
            req_type = 2'($urandom_range(0, 2));
            req_priv_m = 1'($urandom_range(0, 1));
            req_valid = 1'b1; rsp_ready = 1'b1;
            exp = m_fault(req_addr, req_size, req_type, req_priv_m);
            @(posedge clk);
            #1;
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_fault !== exp) begin n_fail++; $display("FAIL b2b[%0d]: got v=%b f=%b want v=1 f=%b", c, rsp_valid, rsp_fault, exp); end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        csr_wr(12'h3B0, 64'h400);
        csr_wr(12'h3A0, 64'h09);
        @(negedge clk);
        req_addr = 64'h10; req_size = 2'd2; req_type = T_WRITE; req_priv_m = 1'b0;
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (rsp_fault !== 1'b1) begin n_fail++; $display("FAIL bp_first: got %b want 1", rsp_fault); end
        rsp_ready = 1'b0;
        req_type = T_READ;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_fault !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d]: got rdy=%b v=%b f=%b want 0/1/1", c, req_ready, rsp_valid, rsp_fault); end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", req_ready); end
        @(posedge clk);
        #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0) begin n_fail++; $display("FAIL bp_release_accept: got v=%b f=%b want 1/0", rsp_valid, rsp_fault); end
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_reset_drop: got %b want 0", rsp_valid); end
        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        m_clear();
    endtask

    task automatic test_random();
        logic [63:0] d, cfgw, a;
        logic        h, f, v, exp;
        longint unsigned val;
        int k;
        logic [7:0] b;
        logic [11:0] ra;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int e = 0; e < N; e++) begin
                case ($urandom_range(0, 4))
                    0, 1: val = 64'($urandom_range(0, 32'h2400));
                    2, 3: begin
                        k = int'($urandom_range(0, 8));
                        val = (64'($urandom_range(0, 15)) << (k + 1)) | ((64'd1 << k) - 64'd1);
                    end
                    default: val = 64'hFFFF_FFFF_FFFF_FFFF;
                endcase
                csr_wr(12'h3B0 + 12'(e), val);
            end
            for (int w = 0; w < 2; w++) begin
                cfgw = 64'd0;
                for (int j = 0; j < 8; j++) begin
                    b = 8'($urandom);
                    b[7] = ($urandom_range(0, 3) == 0);
                    cfgw[8*j +: 8] = b;
                end
                csr_wr(12'h3A0, cfgw);
            end
            for (int e = 0; e < N; e++) begin
                csr_wr(12'h3B0 + 12'(e), 64'($urandom_range(0, 32'h2400)));
            end
            for (int i = 0; i < 20; i++) begin
                ra = (i < 4) ? 12'h3A0 + 12'(i) : 12'h3B0 + 12'(i - 4);
                csr_rd(ra, d, h);
                n_cmp++; if (d !== m_read(ra) || h !== m_hit(ra)) begin n_fail++; $display("FAIL rnd_csr[%0d] %h: got %h/%b want %h/%b", r, ra, d, h, m_read(ra), m_hit(ra)); end
            end
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 7) == 0)
                    a = ({32'($urandom), 32'($urandom)} & ~c_PMASK) | (c_PMASK - 64'($urandom_range(0, 8)));
                else
                    a = 64'($urandom_range(0, 32'h9000));
                exp = m_fault(a, 2'($urandom_range(0, 3)), 2'd0, 1'b0);
                req_size = 2'($urandom_range(0, 3));
                req_type = 2'($urandom_range(0, 2));
                req_priv_m = 1'($urandom_range(0, 1));
                exp = m_fault(a, req_size, req_type, req_priv_m);
                issue(a, req_size, req_type, req_priv_m, f, v);
                n_cmp++; if (f !== exp || v !== 1'b1) begin n_fail++; $display("FAIL rnd_req[%0d.%0d] a=%h sz=%0d ty=%0d m=%b: got f=%b v=%b want f=%b v=1", r, i, a, req_size, req_type, req_priv_m, f, v, exp); end
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; csr_we = 1'b0; csr_addr = 12'h0; csr_wdata = 64'h0;
        req_valid = 1'b0; req_addr = 64'h0; req_size = 2'd0; req_type = 2'd0;
        req_priv_m = 1'b0; rsp_ready = 1'b1;
        m_clear();
        test_reset();
        test_tor();
        test_napot();
        test_lock();
        test_warl();
        test_csr_same_cycle();
        test_back_to_back();
        test_backpressure();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1);
    end

endmodule
`default_nettype wire
